// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Bundle of fetch, data-access, stall and memory-port signals
//            shared between the core, the memory and mem_port_arbiter.
//            slave  = arbiter view, master = core/memory view.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch (F stage)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  // Load/store (M stage)
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  // Pipeline freeze
  logic              stall_F;
  logic              stall_M;
  // Shared memory port
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_ack, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata,
    output stall_F, stall_M,
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_ack, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata,
    input  stall_F, stall_M,
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and load/store.
//            Data accesses win; a fetch that completes while the pipeline is
//            frozen by a data access is held in ir_q until it can be handed
//            over. Generates stall_F / stall_M for the pipeline enables.
// Options  : MEM_ARB_IBUF_EN - one-entry fetch buffer (tag, word, valid) that
//            serves a repeated fetch address without a memory access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_I_ACC  = 2'd1,
    S_D_ACC  = 2'd2,
    S_D_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_start_d;
  logic              w_start_i;
  logic              w_buf_hit;
  logic              w_mem_valid;
  logic              w_dm_ack;
  logic              w_i_done;
  logic              w_d_done;
  logic              w_stall_M;
  logic              w_if_ack;
  logic              w_ibuf_match;
  logic [DATA_W-1:0] w_buf_word;

  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_ir_q;
  logic              r_ir_valid;
  logic              r_drop_q;
  logic [DATA_W-1:0] r_dm_rdata;

  assign w_i_done = (r_state == S_I_ACC) && bus.mem_ready;
  assign w_d_done = (r_state == S_D_ACC) && bus.mem_ready;

  // Stalls are forced low while reset is asserted so the pipeline sees a
  // clean, non-frozen state even if requests are still being presented.
  assign w_stall_M = reset_n & bus.dm_req & ~w_dm_ack;
  assign w_if_ack  = r_ir_valid & ~w_stall_M & ~bus.if_flush;

  // Next-state and transfer strobes; data access has fixed priority.
  always_comb begin
    w_state_nxt = r_state;
    w_start_d   = 1'b0;
    w_start_i   = 1'b0;
    w_buf_hit   = 1'b0;
    w_mem_valid = 1'b0;
    w_dm_ack    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.dm_req) begin
          w_start_d   = 1'b1;
          w_state_nxt = S_D_ACC;
        end else if (bus.if_req && !r_ir_valid && !bus.if_flush) begin
          if (w_ibuf_match) begin
            w_buf_hit = 1'b1;
          end else begin
            w_start_i   = 1'b1;
            w_state_nxt = S_I_ACC;
          end
        end
      end
      S_I_ACC: begin
        w_mem_valid = 1'b1;
        if (bus.mem_ready) w_state_nxt = S_IDLE;
      end
      S_D_ACC: begin
        w_mem_valid = 1'b1;
        if (bus.mem_ready) w_state_nxt = S_D_DONE;
      end
      S_D_DONE: begin
        w_dm_ack    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Memory request registers, loaded when a transaction is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else if (w_start_d) begin
      r_mem_addr  <= bus.dm_addr;
      r_mem_wdata <= bus.dm_wdata;
      r_mem_we    <= bus.dm_we;
    end else if (w_start_i) begin
      r_mem_addr  <= bus.if_addr;
      r_mem_we    <= 1'b0;
    end
  end

  // Held fetch word, its valid flag, and the drop flag for flushed fetches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir_q     <= '0;
      r_ir_valid <= 1'b0;
      r_drop_q   <= 1'b0;
    end else if (w_i_done) begin
      r_ir_q     <= bus.mem_rdata;
      r_ir_valid <= ~r_drop_q & ~bus.if_flush;
      r_drop_q   <= 1'b0;
    end else begin
      if ((r_state == S_I_ACC) && bus.if_flush) r_drop_q <= 1'b1;
      if (bus.if_flush || w_if_ack) begin
        r_ir_valid <= 1'b0;
      end else if (w_buf_hit) begin
        r_ir_q     <= w_buf_word;
        r_ir_valid <= 1'b1;
      end
    end
  end

  // Load data capture; a store leaves the previous load value in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   r_dm_rdata <= '0;
    else if (w_d_done && !r_mem_we) r_dm_rdata <= bus.mem_rdata;
  end

`ifdef MEM_ARB_IBUF_EN
  logic [ADDR_W-1:0] r_ir_tag;
  logic [ADDR_W-1:0] r_buf_tag;
  logic [DATA_W-1:0] r_buf_word;
  logic              r_buf_valid;

  assign w_ibuf_match = r_buf_valid && (r_buf_tag == bus.if_addr);
  assign w_buf_word   = r_buf_word;

  // Address of the word currently held in ir_q, used to tag the buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_ir_tag <= '0;
    else if (w_i_done)  r_ir_tag <= r_mem_addr;
    else if (w_buf_hit) r_ir_tag <= r_buf_tag;
  end

  // Fetch buffer: any store invalidates it, every delivered fetch refills it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_tag   <= '0;
      r_buf_word  <= '0;
      r_buf_valid <= 1'b0;
    end else if ((r_state == S_D_ACC) && r_mem_we) begin
      r_buf_valid <= 1'b0;
    end else if (w_if_ack) begin
      r_buf_tag   <= r_ir_tag;
      r_buf_word  <= r_ir_q;
      r_buf_valid <= 1'b1;
    end
  end
`else
  assign w_ibuf_match = 1'b0;
  assign w_buf_word   = '0;
`endif

  assign bus.if_ack    = w_if_ack;
  assign bus.if_rdata  = r_ir_q;
  assign bus.dm_ack    = w_dm_ack;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.stall_M   = w_stall_M;
  assign bus.stall_F   = reset_n & ((bus.if_req & ~w_if_ack) | w_stall_M);
  assign bus.mem_valid = w_mem_valid;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter: single-transaction
//            vector table plus hand-written multi-cycle sequences; returned
//            words are checked against a scoreboard queue on each ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  int   wait_cfg;
  int   wcnt;
  int   n_memcyc;
  logic [31:0] mem [0:255];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model with programmable wait states, plus the ack scoreboard.
  always @(negedge clk) begin
    if (!reset_n || !bus.mem_valid) begin
      bus.mem_ready = 1'b0;
      wcnt = 0;
    end else begin
      n_memcyc++;
      if (wcnt == wait_cfg) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr[9:2]];
        if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
        wcnt = 0;
      end else begin
        bus.mem_ready = 1'b0;
        wcnt++;
      end
    end
    if (reset_n && bus.dm_ack) begin
      if (exp_d.size() == 0) check("dm_ack_unexpected", 1, 0);
      else check("dm_rdata", bus.dm_rdata, exp_d.pop_front());
    end
    if (reset_n && bus.if_ack) begin
      if (exp_i.size() == 0) check("if_ack_unexpected", 1, 0);
      else check("if_rdata", bus.if_rdata, exp_i.pop_front());
    end
  end

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wt;
    int          exp_lat;
    logic [31:0] exp_data;
  } vec_t;

  // One isolated transaction: checks ack latency, stall behaviour and the
  // number of cycles the memory port was busy.
  task automatic do_txn(input string name, input bit fetch, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int wt, input int exp_lat, input logic [31:0] exp_data,
                        input int exp_mem);
    int lat;
    int mem0;
    int stall_err;
    lat = -1;
    stall_err = 0;
    @(posedge clk); #1;
    wait_cfg = wt;
    mem0 = n_memcyc;
    if (fetch) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
      exp_i.push_back(exp_data);
    end else begin
      bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
      exp_d.push_back(exp_data);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (fetch ? bus.if_ack : bus.dm_ack) begin
        lat = c;
        if (fetch ? bus.stall_F : bus.stall_M) stall_err++;
        break;
      end
      if (!(fetch ? bus.stall_F : bus.stall_M)) stall_err++;
      @(posedge clk); #1;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_stall"}, 64'(stall_err), 64'd0);
    check({name, "_memcycles"}, 64'(n_memcyc - mem0), 64'(exp_mem));
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    int d_lat;
    int i_lat;
    n_tests = 0; n_fail = 0; n_memcyc = 0; wcnt = 0; wait_cfg = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[8'h10] = 32'hDEAD_BEEF;

    vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,         0, 2, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h44,  32'h1111_2222, 0, 2, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b0, 32'h44,  32'h0,         2, 4, 32'h1111_2222};
    vecs[3] = '{1'b1, 1'b0, 32'h100, 32'h0,         0, 2, 32'hA000_0040};
    vecs[4] = '{1'b1, 1'b0, 32'h104, 32'h0,         3, 5, 32'hA000_0041};
    vecs[5] = '{1'b0, 1'b0, 32'h48,  32'h0,         1, 3, 32'hA000_0012};

    // Reset with requests pending: every output must read zero.
    reset_n = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0; bus.if_flush = 1'b0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {bus.mem_valid, bus.mem_we, bus.if_ack, bus.dm_ack, bus.stall_F, bus.stall_M}, 6'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 64'h0);
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    for (int v = 0; v < 6; v++)
      do_txn($sformatf("vec%0d", v), vecs[v].fetch, vecs[v].we, vecs[v].addr,
             vecs[v].wdata, vecs[v].wt, vecs[v].exp_lat, vecs[v].exp_data, vecs[v].wt + 1);

    // Simultaneous store and fetch: store goes first, fetch acked in cycle 5.
    @(posedge clk); #1;
    wait_cfg = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h80; bus.dm_wdata = 32'h1234_5678;
    exp_d.push_back(32'hA000_0012);
    exp_i.push_back(32'hA000_0040);
    d_lat = -1; i_lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("both_store_ctrl", {bus.mem_valid, bus.mem_we}, 2'b11);
        check("both_store_addr", bus.mem_addr, 32'h80);
        check("both_store_wdata", bus.mem_wdata, 32'h1234_5678);
      end
      if (c == 4) begin
        check("both_fetch_ctrl", {bus.mem_valid, bus.mem_we}, 2'b10);
        check("both_fetch_addr", bus.mem_addr, 32'h100);
      end
      if (bus.dm_ack && d_lat < 0) d_lat = c;
      if (bus.if_ack && i_lat < 0) i_lat = c;
      if (i_lat >= 0) break;
      @(posedge clk); #1;
      if (d_lat >= 0) begin bus.dm_req = 1'b0; bus.dm_we = 1'b0; end
    end
    check("both_dm_latency", 64'(d_lat), 64'd2);
    check("both_if_latency", 64'(i_lat), 64'd5);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;

    do_txn("readback_store", 1'b0, 1'b0, 32'h80, 32'h0, 0, 2, 32'h1234_5678, 1);

    // Flush during a 3-wait fetch: first word dropped, redirected fetch served.
    @(posedge clk); #1;
    wait_cfg = 3;
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    exp_i.push_back(32'hA000_00C1);
    i_lat = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 6) check("flush_new_addr", bus.mem_addr, 32'h304);
      if (bus.if_ack) begin i_lat = c; break; end
      @(posedge clk); #1;
      if (c + 1 == 2) bus.if_flush = 1'b1;
      if (c + 1 == 3) begin bus.if_flush = 1'b0; bus.if_addr = 32'h304; end
    end
    check("flush_if_latency", 64'(i_lat), 64'd10);
    @(posedge clk); #1;
    bus.if_req = 1'b0;

    // Fetch finishes while a 4-wait load stalls: ack withheld until dm_ack.
    @(posedge clk); #1;
    wait_cfg = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h108;
    exp_i.push_back(32'hA000_0042);
    d_lat = -1; i_lat = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.dm_ack && d_lat < 0) d_lat = c;
      if (bus.if_ack && i_lat < 0) i_lat = c;
      if (d_lat >= 0 && i_lat >= 0) break;
      @(posedge clk); #1;
      if (c + 1 == 1) begin
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h48;
        exp_d.push_back(32'hA000_0012);
      end
      if (c + 1 == 2) wait_cfg = 4;
    end
    check("hold_dm_latency", 64'(d_lat), 64'd8);
    check("hold_if_latency", 64'(i_lat), 64'd8);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.dm_req = 1'b0;

    // Reset asserted in D_ACC: outputs clear at once, then normal service.
    @(posedge clk); #1;
    wait_cfg = 5;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h4C;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_busy", bus.mem_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("arst_ctrl", {bus.mem_valid, bus.mem_we, bus.if_ack, bus.dm_ack, bus.stall_F, bus.stall_M}, 6'b0);
    check("arst_mem_addr", bus.mem_addr, 32'h0);
    check("arst_rdata", {bus.if_rdata, bus.dm_rdata}, 64'h0);
    bus.dm_req = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    do_txn("post_reset_load", 1'b0, 1'b0, 32'h4C, 32'h0, 0, 2, 32'hA000_0013, 1);

    // Repeated fetch of 0x200 around a store.
    do_txn("ibuf_f1", 1'b1, 1'b0, 32'h200, 32'h0, 0, 2, 32'hA000_0080, 1);
`ifdef MEM_ARB_IBUF_EN
    do_txn("ibuf_f2", 1'b1, 1'b0, 32'h200, 32'h0, 0, 1, 32'hA000_0080, 0);
`else
    do_txn("ibuf_f2", 1'b1, 1'b0, 32'h200, 32'h0, 0, 2, 32'hA000_0080, 1);
`endif
    do_txn("ibuf_store", 1'b0, 1'b1, 32'h90, 32'h5555_AAAA, 0, 2, 32'hA000_0013, 1);
    do_txn("ibuf_f3", 1'b1, 1'b0, 32'h200, 32'h0, 0, 2, 32'hA000_0080, 1);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(exp_i.size() + exp_d.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port of the pipelined core between instruction fetch (F stage) and load/store (M stage), sequencing multi-cycle memory transactions through a small FSM. Produces the stall signals that freeze the pipeline while a requester waits, and holds a completed fetch whenever the pipeline is frozen by a data access, so no fetched word is lost. Sits beside the hazard logic in the datapath; its stalls are ORed into the existing PC/F-D enables.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width

- clk  in  1  clock, rising edge
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- if_req  in  1  fetch request; if_addr held stable while stall_F=1
- if_addr  in  ADDR_W  fetch address (PC)
- if_flush  in  1  branch/jump redirect; discards pending or held fetch
- if_ack  out  1  fetch complete; if_rdata valid this cycle
- if_rdata  out  DATA_W  fetched instruction (registered)
- dm_req  in  1  data request; inputs held stable while stall_M=1
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_ack  out  1  data access complete; dm_rdata valid this cycle
- dm_rdata  out  DATA_W  load data (registered)
- stall_F  out  1  freeze PC and F/D register
- stall_M  out  1  freeze PC through E/M; bubble into M/W
- mem_valid  out  1  memory request active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_ready  in  1  memory completes transfer this cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready

## Operation
- States: IDLE, I_ACC, D_ACC, D_DONE. Held-fetch register ir_q with flag ir_valid; drop flag drop_q.
- IDLE: dm_req -> latch dm_addr/dm_wdata/dm_we into mem_* regs, go D_ACC. Else if_req & ~ir_valid & ~if_flush -> latch if_addr, mem_we=0, go I_ACC. Data has fixed priority.
- I_ACC / D_ACC: mem_valid=1, address/data stable. Stay until mem_ready.
- I_ACC & mem_ready: ir_q <= mem_rdata; ir_valid <= ~drop_q & ~if_flush; drop_q <= 0; -> IDLE.
- D_ACC & mem_ready: dm_rdata <= mem_rdata (loads; unchanged for stores); -> D_DONE.
- D_DONE: dm_ack=1 for exactly one cycle; -> IDLE (next request can be accepted from that IDLE cycle).
- if_flush during I_ACC: drop_q <= 1; transaction completes on memory, result discarded. if_flush with ir_valid: ir_valid <= 0.
- stall_M = dm_req & ~dm_ack.
- if_ack = ir_valid & ~stall_M & ~if_flush; if_rdata = ir_q; ir_valid cleared on the edge ending the ack cycle.
- stall_F = (if_req & ~if_ack) | stall_M.
- mem_ready outside I_ACC/D_ACC ignored.

## Timing
- Reset (async, reset_n=0): state IDLE; ir_valid, drop_q, mem_valid, mem_we, if_ack, dm_ack, stall_F, stall_M = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0. Reset mid-transaction abandons it; memory must tolerate mem_valid dropping.
- Data, memory ready immediately: req in IDLE cycle 0, D_ACC cycle 1 (mem_ready=1), dm_ack cycle 2. stall_M=1 in cycles 0-1.
- Fetch, memory ready immediately: req cycle 0, I_ACC cycle 1, if_ack cycle 2.
- Each extra memory wait cycle adds one cycle to either path.
- Both requests in one IDLE cycle: data first; fetch starts in the IDLE after D_DONE; minimum 5 cycles to if_ack.
- Fetch completes while dm_req high: word held in ir_q, if_ack withheld until stall_M=0 (may coincide with dm_ack).

## Configuration
- MEM_ARB_IBUF_EN defined: one-entry fetch buffer (tag, word, valid). Every if_ack updates it. In IDLE, if_req & ~ir_valid & ~dm_req & tag==if_addr & valid -> ir_valid <= 1 without memory access (if_ack next cycle). Any store (D_ACC with mem_we) invalidates it. Reset invalidates it.
- Not defined: every fetch goes to memory; no buffer logic.

## Test plan
- Load, mem_ready tied 1: dm_req, dm_addr=0x40, memory returns 0xDEADBEEF -> mem_valid cycle 1 only, dm_ack+dm_rdata=0xDEADBEEF cycle 2, stall_M=1 cycles 0-1.
- Simultaneous if_req (0x100) and dm store (0x80, 0x12345678) -> store issued first with mem_we=1, fetch at 0x100 next, if_ack cycle 5.
- Fetch in I_ACC with 3 wait cycles, if_flush pulsed during wait -> result discarded, no if_ack, next fetch uses new if_addr.
- Fetch completes while load stalls 4 cycles -> if_ack withheld, asserted same cycle as dm_ack with correct held word.
- reset_n low during D_ACC -> all outputs zero immediately, state IDLE; new request after release serviced normally.
- MEM_ARB_IBUF_EN: fetch 0x200 twice -> second ack with no mem_valid; after store to any address, third fetch of 0x200 accesses memory.
